// File: rtl/mem_if_pkg.sv
// Shared definitions for the processor memory interface: word geometry and the
// responder's sweep/serve state type.
package mem_if_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } mem_state_t;

endpackage : mem_if_pkg

// File: rtl/mem_word_responder_if.sv
// Request/response bundle between the processor (master) and the word store (slave).
// parity_err exists only when PARITY_CHK_EN is defined.
interface mem_word_responder_if #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int DATA_W = mem_if_pkg::DATA_W
) ();

  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready;
`ifdef PARITY_CHK_EN
  logic              parity_err;
`endif

`ifdef PARITY_CHK_EN
  modport master (
    output write_enable, address, data_in,
    input  data_out, ready, parity_err
  );
  modport slave (
    input  write_enable, address, data_in,
    output data_out, ready, parity_err
  );
`else
  modport master (
    output write_enable, address, data_in,
    input  data_out, ready
  );
  modport slave (
    input  write_enable, address, data_in,
    output data_out, ready
  );
`endif

endinterface : mem_word_responder_if

// File: rtl/mem_word_responder.sv
// 2**ADDR_W x DATA_W synchronous word store that clears itself after reset, then serves
// write-first reads with one cycle of latency. Define PARITY_CHK_EN for per-word even parity.
module mem_word_responder #(
  parameter int                ADDR_W   = mem_if_pkg::ADDR_W,
  parameter int                DATA_W   = mem_if_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  mem_word_responder_if.slave bus
);

  import mem_if_pkg::mem_state_t, mem_if_pkg::INIT, mem_if_pkg::IDLE;

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
`ifdef PARITY_CHK_EN
  localparam int                WORD_W    = DATA_W + 1;
`else
  localparam int                WORD_W    = DATA_W;
`endif

  // Stored word layout: {parity, data} when parity is enabled, plain data otherwise.
  function automatic logic [WORD_W-1:0] make_word(input logic [DATA_W-1:0] d);
`ifdef PARITY_CHK_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [WORD_W-1:0] mem_q [DEPTH];

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ready_q, ready_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] rd_word;
  logic              rd_chk;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the sweep counter stops on the last word instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: state_d = IDLE;
    endcase
  end

  // Outputs. An unknown write_enable falls through to the read branch.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = bus.address;
    mem_wdata  = make_word(bus.data_in);
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    rd_chk     = 1'b0;
    rd_word    = mem_q[bus.address];
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = cnt_q;
        mem_wdata  = make_word(INIT_VAL);
        data_out_d = '0;
        ready_d    = (cnt_q == LAST_ADDR);
      end
      IDLE: begin
        ready_d = 1'b1;
        if (bus.write_enable) begin
          mem_we     = 1'b1;
          data_out_d = bus.data_in;
        end else begin
          rd_chk     = 1'b1;
          data_out_d = rd_word[DATA_W-1:0];
        end
      end
    endcase
  end

  // Storage has no reset; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = ready_q;

`ifdef PARITY_CHK_EN
  logic parity_err_q, parity_err_d;

  // A consistent word has even parity over {parity, data}; odd means corruption.
  always_comb begin
    parity_err_d = parity_err_q | (rd_chk & (^rd_word));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  logic unused_rd_chk;
  assign unused_rd_chk = rd_chk;
`endif

endmodule : mem_word_responder

// File: tb/tb_mem_word_responder.sv
// Directed bench for mem_word_responder: a reference memory model checked every cycle,
// plus literal expectations at the interesting points. Define PARITY_CHK_EN to cover parity.
module tb_mem_word_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_word_responder_if bus ();

  mem_word_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the store is all zero 256 clock edges after reset releases,
  // then writes land immediately and echo, reads return the stored word.
  logic [31:0] model_mem [256];
  bit          corrupt   [256];
  int          init_done = 0;
  logic        exp_ready = 1'b0;
  logic [31:0] exp_dout  = '0;
  logic        exp_par   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done = 0;
      exp_ready = 1'b0;
      exp_dout  = '0;
      exp_par   = 1'b0;
    end else if (init_done < 256) begin
      model_mem[init_done] = 32'h0;
      corrupt[init_done]   = 1'b0;
      init_done            = init_done + 1;
      exp_dout             = '0;
      exp_ready            = (init_done == 256);
    end else if (bus.write_enable === 1'b1) begin
      model_mem[bus.address] = bus.data_in;
      corrupt[bus.address]   = 1'b0;
      exp_dout               = bus.data_in;
    end else begin
      exp_dout = model_mem[bus.address];
      if (corrupt[bus.address]) exp_par = 1'b1;
    end
  end

  // Every-cycle comparison against the model, well away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.ready !== exp_ready) begin
        n_bad++;
        $display("FAIL ready_cycle t=%0t: got %b expected %b", $time, bus.ready, exp_ready);
      end
      n_cmp++;
      if (bus.data_out !== exp_dout) begin
        n_bad++;
        $display("FAIL dout_cycle t=%0t: got %h expected %h", $time, bus.data_out, exp_dout);
      end
`ifdef PARITY_CHK_EN
      n_cmp++;
      if (bus.parity_err !== exp_par) begin
        n_bad++;
        $display("FAIL parity_cycle t=%0t: got %b expected %b", $time, bus.parity_err, exp_par);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request per call; inputs change on the falling edge, result visible after it.
  task automatic txn(input logic we, input logic [7:0] a, input logic [31:0] d);
    bus.write_enable = we;
    bus.address      = a;
    bus.data_in      = d;
    @(negedge clk);
    $display("txn we=%b addr=%h din=%h -> dout=%h ready=%b", we, a, d, bus.data_out, bus.ready);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.ready !== 1'b1 && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n;

  initial begin
    bus.write_enable = 1'b0;
    bus.address      = '0;
    bus.data_in      = '0;

    // 1: reset, sweep length, cleared contents
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("ready_after_rst", {31'b0, bus.ready}, 32'h0);
    wait_ready(n);
    chk("sweep_cycles", n, 32'd256);
    txn(1'b0, 8'h00, 32'hFFFF_FFFF);
    chk("read_00_zero", bus.data_out, 32'h0);
    txn(1'b0, 8'h7F, 32'h0);
    chk("read_7f_zero", bus.data_out, 32'h0);
    txn(1'b0, 8'hFF, 32'h0);
    chk("read_ff_zero", bus.data_out, 32'h0);

    // 2: write then read
    txn(1'b1, 8'h10, 32'hDEAD_BEEF);
    chk("wr_echo_10", bus.data_out, 32'hDEAD_BEEF);
    txn(1'b0, 8'h10, 32'h0);
    chk("rd_10", bus.data_out, 32'hDEAD_BEEF);

    // 3: back-to-back writes to the same word
    txn(1'b1, 8'h05, 32'h1111_1111);
    chk("wr_echo_05a", bus.data_out, 32'h1111_1111);
    txn(1'b1, 8'h05, 32'h2222_2222);
    chk("wr_echo_05b", bus.data_out, 32'h2222_2222);
    txn(1'b0, 8'h05, 32'h0);
    chk("rd_05", bus.data_out, 32'h2222_2222);

    // 4: extremes of the address range do not alias
    txn(1'b1, 8'hFF, 32'hA5A5_A5A5);
    txn(1'b1, 8'h00, 32'h5A5A_5A5A);
    txn(1'b0, 8'hFF, 32'h0);
    chk("rd_ff", bus.data_out, 32'hA5A5_A5A5);
    txn(1'b0, 8'h00, 32'h0);
    chk("rd_00", bus.data_out, 32'h5A5A_5A5A);

    // Unknown write_enable must behave as a read and leave the word alone
    txn(1'bx, 8'h10, 32'h0BAD_0BAD);
    chk("x_we_reads", bus.data_out, 32'hDEAD_BEEF);
    txn(1'b0, 8'h10, 32'h0);
    chk("x_we_no_write", bus.data_out, 32'hDEAD_BEEF);

    // A handful of scattered writes/reads, checked by the model only
    for (int i = 0; i < 8; i++) begin
      txn(1'b1, 8'(8'h40 + i * 9), 32'hC0DE_0000 + 32'(i * 32'h1357));
    end
    for (int i = 7; i >= 0; i--) begin
      txn(1'b0, 8'(8'h40 + i * 9), 32'h0);
    end

    // 5: reset mid-sweep restarts the whole sweep
    pulse_rst();
    repeat (100) @(negedge clk);
    chk("ready_mid_sweep", {31'b0, bus.ready}, 32'h0);
    pulse_rst();
    wait_ready(n);
    chk("sweep_after_mid_rst", n, 32'd256);
    txn(1'b1, 8'h20, 32'h1234_5678);
    txn(1'b0, 8'h20, 32'h0);
    chk("rd_20_before_rst", bus.data_out, 32'h1234_5678);
    bus.write_enable = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_drops_async", {31'b0, bus.ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    chk("sweep_after_traffic_rst", n, 32'd256);
    txn(1'b0, 8'h20, 32'h0);
    chk("rd_20_after_reinit", bus.data_out, 32'h0);
    txn(1'b0, 8'h10, 32'h0);
    chk("rd_10_after_reinit", bus.data_out, 32'h0);

`ifdef PARITY_CHK_EN
    // 6: corrupt a stored parity bit and watch the sticky flag
    txn(1'b1, 8'h30, 32'h0000_0007);
    txn(1'b0, 8'h30, 32'h0);
    chk("parity_clean", {31'b0, bus.parity_err}, 32'h0);
    dut.mem_q[8'h30][32] = ~dut.mem_q[8'h30][32];
    corrupt[8'h30] = 1'b1;
    txn(1'b0, 8'h30, 32'h0);
    chk("parity_set", {31'b0, bus.parity_err}, 32'h1);
    txn(1'b0, 8'h31, 32'h0);
    chk("parity_sticky", {31'b0, bus.parity_err}, 32'h1);
    pulse_rst();
    chk("parity_cleared", {31'b0, bus.parity_err}, 32'h0);
    wait_ready(n);
    txn(1'b0, 8'h30, 32'h0);
    chk("parity_after_reinit", {31'b0, bus.parity_err}, 32'h0);
`endif

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_word_responder
